pos_ram_ctrl: RTL

- Sequencer/arbiter for one single-port position RAM: 32-bit words, 2-cycle registered read (posx/posy/posz class).
- Shares the RAM between two requesters:
  - a burst read stream that feeds the force pipeline (start address + count → tagged position stream);
  - a motion-update write port.
- One instance per coordinate RAM; sits between the RAM and the range-limited pipeline front end.

---
 rtl/pos_ram_ctrl.sv | 237 +++++++++++++++++++++++
 1 files changed

// File: rtl/pos_ram_ctrl.sv
// pos_ram_ctrl: sequencer/arbiter for one single-port position RAM.
// It shares the RAM between a burst read stream (start address + count ->
// an address-tagged word stream) and a motion-update write port.
// The RAM ports are registered, and a {valid, addr, last} tag pipeline
// follows the RAM read latency.
// Optional build macro POS_RAM_FAIR_ARB_EN: when it is defined, four
// back-to-back write grants in STREAM force the next slot to be a read.
module pos_ram_ctrl #(
    parameter int DEPTH        = 512,
    parameter int ADDR_WIDTH   = 9,
    parameter int READ_LATENCY = 2
) (
    input  logic                  clock,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [ADDR_WIDTH:0]   rd_count,
    output logic                  busy,
    output logic                  done,
    input  logic                  wr_req,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [31:0]           wr_data,
    output logic                  wr_ack,
    output logic                  out_valid,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic [31:0]           out_data,
    output logic                  out_last,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic [31:0]           ram_data,
    output logic                  ram_rden,
    output logic                  ram_wren,
    input  logic [31:0]           ram_q
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2
    } state_t;

    // Counts above DEPTH are clamped so that a burst never reads more than the RAM holds.
    localparam logic [ADDR_WIDTH:0]   MAX_COUNT = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   ONE_CNT   = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0]   ZERO_CNT  = {(ADDR_WIDTH+1){1'b0}};
    localparam logic [ADDR_WIDTH-1:0] ONE_PTR   = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    state_t                  state_r, state_s;
    logic [ADDR_WIDTH-1:0]   rd_ptr_r, rd_ptr_s;
    logic [ADDR_WIDTH:0]     remaining_r, remaining_s;
    logic                    busy_r, done_r, done_s;
    logic                    wr_grant_s, rd_grant_s, rd_last_s;
    logic                    force_rd_s, pipe_empty_s;

    logic                    ram_rden_r, ram_wren_r, tag_last_r;
    logic [ADDR_WIDTH-1:0]   ram_address_r;
    logic [31:0]             ram_data_r;

    logic [READ_LATENCY-1:0] pv_r, pl_r;
    logic [ADDR_WIDTH-1:0]   pa_r [READ_LATENCY];

    logic                    out_valid_r, out_last_r;
    logic [ADDR_WIDTH-1:0]   out_addr_r;
    logic [31:0]             out_data_r;

`ifdef POS_RAM_FAIR_ARB_EN
    logic [2:0] wr_run_r;

    assign force_rd_s = (wr_run_r == 3'd4);

    // Run length of consecutive write grants inside STREAM; cleared by any read or outside STREAM.
    always_ff @(posedge clock) begin
        if (rst) begin
            wr_run_r <= 3'd0;
        end else if ((state_r != ST_STREAM) || rd_grant_s) begin
            wr_run_r <= 3'd0;
        end else if (wr_grant_s) begin
            wr_run_r <= wr_run_r + 3'd1;
        end else begin
            wr_run_r <= wr_run_r;
        end
    end
`else
    assign force_rd_s = 1'b0;
`endif

    // The tag pipeline is empty once no read is on the RAM port or in flight.
    assign pipe_empty_s = ~ram_rden_r & ~(|pv_r);

    // Next-state and arbitration: one RAM slot per cycle, writes ahead of reads.
    always_comb begin
        state_s     = state_r;
        rd_ptr_s    = rd_ptr_r;
        remaining_s = remaining_r;
        wr_grant_s  = 1'b0;
        rd_grant_s  = 1'b0;
        rd_last_s   = 1'b0;
        done_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                wr_grant_s = wr_req;
                if (start) begin
                    if (rd_count == ZERO_CNT) begin
                        done_s = 1'b1;
                    end else begin
                        state_s     = ST_STREAM;
                        rd_ptr_s    = start_addr;
                        remaining_s = (rd_count > MAX_COUNT) ? MAX_COUNT : rd_count;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_STREAM: begin
                if (wr_req && !force_rd_s) begin
                    wr_grant_s = 1'b1;
                end else begin
                    rd_grant_s  = 1'b1;
                    rd_ptr_s    = rd_ptr_r + ONE_PTR;
                    remaining_s = remaining_r - ONE_CNT;
                    if (remaining_r == ONE_CNT) begin
                        rd_last_s = 1'b1;
                        state_s   = ST_DRAIN;
                    end else begin
                        state_s = ST_STREAM;
                    end
                end
            end
            ST_DRAIN: begin
                wr_grant_s = wr_req;
                if (pipe_empty_s) begin
                    state_s = ST_IDLE;
                    done_s  = 1'b1;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // FSM state, burst pointer/count and the busy/done status registers.
    always_ff @(posedge clock) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            rd_ptr_r    <= {ADDR_WIDTH{1'b0}};
            remaining_r <= ZERO_CNT;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            rd_ptr_r    <= rd_ptr_s;
            remaining_r <= remaining_s;
            busy_r      <= (state_s != ST_IDLE);
            done_r      <= done_s;
        end
    end

    // RAM port registers: the slot granted this cycle drives the RAM next cycle.
    always_ff @(posedge clock) begin
        if (rst) begin
            ram_rden_r    <= 1'b0;
            ram_wren_r    <= 1'b0;
            tag_last_r    <= 1'b0;
            ram_address_r <= {ADDR_WIDTH{1'b0}};
            ram_data_r    <= 32'd0;
        end else begin
            ram_rden_r <= rd_grant_s;
            ram_wren_r <= wr_grant_s;
            tag_last_r <= rd_grant_s & rd_last_s;
            if (wr_grant_s) begin
                ram_address_r <= wr_addr;
                ram_data_r    <= wr_data;
            end else if (rd_grant_s) begin
                ram_address_r <= rd_ptr_r;
                ram_data_r    <= ram_data_r;
            end else begin
                ram_address_r <= ram_address_r;
                ram_data_r    <= ram_data_r;
            end
        end
    end

    // Tag shift register kept in step with the RAM read latency.
    always_ff @(posedge clock) begin
        if (rst) begin
            pv_r <= {READ_LATENCY{1'b0}};
            pl_r <= {READ_LATENCY{1'b0}};
            for (int i = 0; i < READ_LATENCY; i++) begin
                pa_r[i] <= {ADDR_WIDTH{1'b0}};
            end
        end else begin
            pv_r[0] <= ram_rden_r;
            pl_r[0] <= tag_last_r;
            pa_r[0] <= ram_address_r;
            for (int i = 1; i < READ_LATENCY; i++) begin
                pv_r[i] <= pv_r[i-1];
                pl_r[i] <= pl_r[i-1];
                pa_r[i] <= pa_r[i-1];
            end
        end
    end

    // Output stage: capture ram_q together with its tag.
    always_ff @(posedge clock) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            out_addr_r  <= {ADDR_WIDTH{1'b0}};
            out_data_r  <= 32'd0;
        end else begin
            out_valid_r <= pv_r[READ_LATENCY-1];
            out_last_r  <= pv_r[READ_LATENCY-1] & pl_r[READ_LATENCY-1];
            if (pv_r[READ_LATENCY-1]) begin
                out_addr_r <= pa_r[READ_LATENCY-1];
                out_data_r <= ram_q;
            end else begin
                out_addr_r <= out_addr_r;
                out_data_r <= out_data_r;
            end
        end
    end

    assign busy        = busy_r;
    assign done        = done_r;
    assign wr_ack      = wr_grant_s;
    assign out_valid   = out_valid_r;
    assign out_addr    = out_addr_r;
    assign out_data    = out_data_r;
    assign out_last    = out_last_r;
    assign ram_address = ram_address_r;
    assign ram_data    = ram_data_r;
    assign ram_rden    = ram_rden_r;
    assign ram_wren    = ram_wren_r;

endmodule
